// File: rtl/standoff_referee.sv
// Round referee for a quick-draw duel: arbitrates fouls, first shot, ties and timeouts
// after a roundtime toggle, keeps per-player scores and declares the match winner.
//
// state  | meaning
// IDLE   | after reset, waiting for the first start press
// ARMED  | round armed, waiting for the draw; any shot here is a foul
// DRAW   | draw given, timing reactions until a shot or the timeout
// RESULT | round decided, result held for HOLD_CYCLES
// OVER   | a player reached WIN_SCORE, waiting for start
module standoff_referee #(
    parameter int WIN_SCORE      = 3,
    parameter int TIMEOUT_CYCLES = 150_000_000,
    parameter int HOLD_CYCLES    = 100_000_000,
    parameter int CNT_W          = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pause,
    input  logic             start,
    input  logic             roundtime,
    input  logic             p1_fire,
    input  logic             p2_fire,
    output logic             draw_led,
    output logic [1:0]       winner,
    output logic             result_valid,
    output logic [CNT_W-1:0] reaction_cycles,
    output logic [3:0]       p1_score,
    output logic [3:0]       p2_score,
    output logic             game_over
);

    typedef enum logic [2:0] {IDLE, ARMED, DRAW, RESULT, OVER} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]       WIN          = 4'(WIN_SCORE);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, reaction_n;
    logic [1:0]       winner_n;
    logic [3:0]       p1s_n, p2s_n;
    logic             enter_result;
    logic             start_q, p1_q, p2_q, rt_q;
    logic             start_rise, p1_rise, p2_rise, draw_evt;

    always_comb begin
        // Edges that arrive while paused are dropped, not deferred.
        start_rise   = start & ~start_q & ~pause;
        p1_rise      = p1_fire & ~p1_q & ~pause;
        p2_rise      = p2_fire & ~p2_q & ~pause;
        draw_evt     = (roundtime ^ rt_q) & ~pause;
        state_n      = state;
        cnt_n        = cnt;
        winner_n     = winner;
        reaction_n   = reaction_cycles;
        p1s_n        = p1_score;
        p2s_n        = p2_score;
        enter_result = 1'b0;
        if (!pause) begin
            case (state)
                IDLE: if (start_rise) begin
                    state_n    = ARMED;
                    winner_n   = 2'b00;
                    reaction_n = '0;
                    p1s_n      = '0;
                    p2s_n      = '0;
                end
                ARMED: begin
                    if (p1_rise || p2_rise) begin
                        // A foul awards the round to the other player.
                        winner_n     = {p1_rise, p2_rise};
                        reaction_n   = '0;
                        state_n      = RESULT;
                        enter_result = 1'b1;
                    end else if (draw_evt) begin
                        state_n = DRAW;
                        cnt_n   = '0;
                    end
                end
                DRAW: begin
                    cnt_n = cnt + 1'b1;
                    if (p1_rise || p2_rise) begin
                        winner_n     = {p2_rise, p1_rise};
                        reaction_n   = cnt + 1'b1;
                        state_n      = RESULT;
                        enter_result = 1'b1;
                    end else if (cnt == TIMEOUT_LAST) begin
                        winner_n     = 2'b00;
                        reaction_n   = '0;
                        state_n      = RESULT;
                        enter_result = 1'b1;
                    end
                end
                RESULT: begin
                    if (cnt == HOLD_LAST) begin
                        cnt_n   = '0;
                        state_n = (p1_score == WIN || p2_score == WIN) ? OVER : ARMED;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                OVER: if (start_rise) begin
                    state_n  = ARMED;
                    winner_n = 2'b00;
                    p1s_n    = '0;
                    p2s_n    = '0;
                end
                default: state_n = IDLE;
            endcase
            if (enter_result) begin
                cnt_n = '0;
                if (winner_n == 2'b01 && p1_score < WIN) p1s_n = p1_score + 4'd1;
                if (winner_n == 2'b10 && p2_score < WIN) p2s_n = p2_score + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        start_q <= start;
        p1_q    <= p1_fire;
        p2_q    <= p2_fire;
        rt_q    <= roundtime;
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            draw_led        <= 1'b0;
            winner          <= 2'b00;
            result_valid    <= 1'b0;
            reaction_cycles <= '0;
            p1_score        <= '0;
            p2_score        <= '0;
            game_over       <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            draw_led        <= (state_n == DRAW);
            winner          <= winner_n;
            result_valid    <= enter_result;
            reaction_cycles <= reaction_n;
            p1_score        <= p1s_n;
            p2_score        <= p2s_n;
            game_over       <= (state_n == OVER);
        end
    end

endmodule

// File: tb/tb_standoff_referee.sv
// Directed bench for standoff_referee with short timeout/hold constants and WIN_SCORE=2.
module tb_standoff_referee;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset, pause, start, roundtime, p1_fire, p2_fire;
    logic          draw_led, result_valid, game_over;
    logic [1:0]    winner;
    logic [CW-1:0] reaction_cycles;
    logic [3:0]    p1_score, p2_score;
    int            vectors = 0;
    int            miscompares = 0;

    standoff_referee #(
        .WIN_SCORE(2), .TIMEOUT_CYCLES(20), .HOLD_CYCLES(5), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .pause(pause), .start(start), .roundtime(roundtime),
        .p1_fire(p1_fire), .p2_fire(p2_fire), .draw_led(draw_led), .winner(winner),
        .result_valid(result_valid), .reaction_cycles(reaction_cycles),
        .p1_score(p1_score), .p2_score(p2_score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic toggle_rt();
        roundtime = ~roundtime;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; pause = 1'b0; start = 1'b0; roundtime = 1'b0;
        p1_fire = 1'b1; p2_fire = 1'b0;
        step(2);
        vectors++;
        if ({draw_led, winner, result_valid, reaction_cycles, p1_score, p2_score, game_over} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got led=%b win=%b rv=%b rc=%0d s1=%0d s2=%0d go=%b want all 0",
                     draw_led, winner, result_valid, reaction_cycles, p1_score, p2_score, game_over);
        end
        reset = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step(2);
        vectors++;
        if ({winner, result_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL held_button_no_shot: got win=%b rv=%b want 00/0", winner, result_valid);
        end
        p1_fire = 1'b0;
        step();
    endtask

    task automatic test_p1_win();
        toggle_rt();
        vectors++;
        if (draw_led !== 1'b1) begin
            miscompares++;
            $display("FAIL draw_led_on: got %b want 1", draw_led);
        end
        step(3);
        p1_fire = 1'b1;
        step();
        vectors++;
        if (draw_led !== 1'b0) begin
            miscompares++;
            $display("FAIL draw_led_off: got %b want 0", draw_led);
        end
        vectors++;
        if (winner !== 2'b01) begin
            miscompares++;
            $display("FAIL p1_win_winner: got %b want 01", winner);
        end
        vectors++;
        if (reaction_cycles !== 8'd4) begin
            miscompares++;
            $display("FAIL p1_win_reaction: got %0d want 4", reaction_cycles);
        end
        vectors++;
        if ({result_valid, p1_score, p2_score} !== {1'b1, 4'd1, 4'd0}) begin
            miscompares++;
            $display("FAIL p1_win_rv_scores: got rv=%b s1=%0d s2=%0d want 1/1/0", result_valid, p1_score, p2_score);
        end
        p1_fire = 1'b0;
        step();
        vectors++;
        if (result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL result_valid_pulse: got %b want 0", result_valid);
        end
    endtask

    task automatic test_hold_to_armed();
        step(3);
        toggle_rt();
        vectors++;
        if (draw_led !== 1'b0) begin
            miscompares++;
            $display("FAIL draw_ignored_in_result: got %b want 0", draw_led);
        end
        toggle_rt();
        vectors++;
        if (draw_led !== 1'b1) begin
            miscompares++;
            $display("FAIL armed_after_hold: got %b want 1", draw_led);
        end
    endtask

    task automatic test_timeout();
        step(19);
        vectors++;
        if ({draw_led, winner, result_valid} !== {1'b1, 2'b01, 1'b0}) begin
            miscompares++;
            $display("FAIL timeout_not_early: got led=%b win=%b rv=%b want 1/01/0", draw_led, winner, result_valid);
        end
        step();
        vectors++;
        if ({draw_led, winner, result_valid, reaction_cycles} !== {1'b0, 2'b00, 1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL timeout_result: got led=%b win=%b rv=%b rc=%0d want 0/00/1/0",
                     draw_led, winner, result_valid, reaction_cycles);
        end
        vectors++;
        if ({p1_score, p2_score} !== {4'd1, 4'd0}) begin
            miscompares++;
            $display("FAIL timeout_scores: got %0d/%0d want 1/0", p1_score, p2_score);
        end
        step(5);
    endtask

    task automatic test_foul_p2();
        p2_fire = 1'b1;
        step();
        vectors++;
        if ({winner, result_valid, reaction_cycles, p1_score} !== {2'b01, 1'b1, 8'd0, 4'd2}) begin
            miscompares++;
            $display("FAIL p2_foul: got win=%b rv=%b rc=%0d s1=%0d want 01/1/0/2",
                     winner, result_valid, reaction_cycles, p1_score);
        end
        p2_fire = 1'b0;
        step(4);
        vectors++;
        if (game_over !== 1'b0) begin
            miscompares++;
            $display("FAIL over_not_early: got %b want 0", game_over);
        end
        step();
        vectors++;
        if ({game_over, winner, p1_score} !== {1'b1, 2'b01, 4'd2}) begin
            miscompares++;
            $display("FAIL p1_match_over: got go=%b win=%b s1=%0d want 1/01/2", game_over, winner, p1_score);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if ({game_over, winner, p1_score, p2_score} !== 11'd0) begin
            miscompares++;
            $display("FAIL restart_clear: got go=%b win=%b s1=%0d s2=%0d want 0", game_over, winner, p1_score, p2_score);
        end
        step();
    endtask

    task automatic test_tie();
        toggle_rt();
        step();
        p1_fire = 1'b1; p2_fire = 1'b1;
        step();
        vectors++;
        if ({winner, result_valid, reaction_cycles, p1_score, p2_score} !== {2'b11, 1'b1, 8'd2, 8'd0}) begin
            miscompares++;
            $display("FAIL draw_tie: got win=%b rv=%b rc=%0d s1=%0d s2=%0d want 11/1/2/0/0",
                     winner, result_valid, reaction_cycles, p1_score, p2_score);
        end
        p1_fire = 1'b0; p2_fire = 1'b0;
        step(5);
        p1_fire = 1'b1; p2_fire = 1'b1;
        step();
        vectors++;
        if ({winner, result_valid, reaction_cycles, p1_score, p2_score} !== {2'b11, 1'b1, 8'd0, 8'd0}) begin
            miscompares++;
            $display("FAIL foul_tie: got win=%b rv=%b rc=%0d s1=%0d s2=%0d want 11/1/0/0/0",
                     winner, result_valid, reaction_cycles, p1_score, p2_score);
        end
        p1_fire = 1'b0; p2_fire = 1'b0;
        step(5);
    endtask

    task automatic test_p2_match();
        toggle_rt();
        p2_fire = 1'b1;
        step();
        vectors++;
        if ({winner, reaction_cycles, p2_score} !== {2'b10, 8'd1, 4'd1}) begin
            miscompares++;
            $display("FAIL p2_round1: got win=%b rc=%0d s2=%0d want 10/1/1", winner, reaction_cycles, p2_score);
        end
        p2_fire = 1'b0;
        step(5);
        p1_fire = 1'b1;
        step();
        vectors++;
        if ({winner, reaction_cycles, p2_score} !== {2'b10, 8'd0, 4'd2}) begin
            miscompares++;
            $display("FAIL p1_foul_gives_p2: got win=%b rc=%0d s2=%0d want 10/0/2", winner, reaction_cycles, p2_score);
        end
        p1_fire = 1'b0;
        step(5);
        vectors++;
        if ({game_over, p2_score} !== {1'b1, 4'd2}) begin
            miscompares++;
            $display("FAIL p2_match_over: got go=%b s2=%0d want 1/2", game_over, p2_score);
        end
        p2_fire = 1'b1;
        step();
        p2_fire = 1'b0;
        vectors++;
        if ({game_over, winner, p2_score} !== {1'b1, 2'b10, 4'd2}) begin
            miscompares++;
            $display("FAIL over_holds: got go=%b win=%b s2=%0d want 1/10/2", game_over, winner, p2_score);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if ({game_over, winner, p1_score, p2_score} !== 11'd0) begin
            miscompares++;
            $display("FAIL p2_restart_clear: got go=%b win=%b s1=%0d s2=%0d want 0", game_over, winner, p1_score, p2_score);
        end
        step();
    endtask

    task automatic test_pause();
        toggle_rt();
        step(2);
        pause = 1'b1;
        step();
        p1_fire = 1'b1;
        step(9);
        vectors++;
        if ({draw_led, winner, result_valid} !== {1'b1, 2'b00, 1'b0}) begin
            miscompares++;
            $display("FAIL pause_frozen: got led=%b win=%b rv=%b want 1/00/0", draw_led, winner, result_valid);
        end
        pause = 1'b0;
        step();
        vectors++;
        if ({draw_led, winner} !== {1'b1, 2'b00}) begin
            miscompares++;
            $display("FAIL pause_edge_dropped: got led=%b win=%b want 1/00", draw_led, winner);
        end
        p1_fire = 1'b0;
        step();
        p1_fire = 1'b1;
        step();
        vectors++;
        if ({winner, reaction_cycles, p1_score} !== {2'b01, 8'd5, 4'd1}) begin
            miscompares++;
            $display("FAIL pause_reaction: got win=%b rc=%0d s1=%0d want 01/5/1", winner, reaction_cycles, p1_score);
        end
        p1_fire = 1'b0;
        step();
    endtask

    task automatic test_reset_midround();
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if ({draw_led, winner, p1_score, result_valid} !== '0) begin
            miscompares++;
            $display("FAIL midround_reset: got led=%b win=%b s1=%0d rv=%b want 0", draw_led, winner, p1_score, result_valid);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_p1_win();
        test_hold_to_armed();
        test_timeout();
        test_foul_p2();
        test_tie();
        test_p2_match();
        test_pause();
        test_reset_midround();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
